// File: rtl/sprite_rom_arb_pkg.sv
// Shared types and defaults for the sprite ROM arbiter.
//   ADDR_W / DATA_W / ROM_DEPTH : default geometry of the 60x26 fireball ROM
//   TRANSPARENT_IDX             : palette index returned for out-of-range reads
//   pipe_entry_t                : one in-flight read (valid, requester id, oor)
package sprite_rom_arb_pkg;
  localparam int          ADDR_W    = 11;
  localparam int          DATA_W    = 3;
  localparam int unsigned ROM_DEPTH = 1560;
  localparam logic [DATA_W-1:0] TRANSPARENT_IDX = '0;

  typedef struct packed {
    logic       vld;
    logic [2:0] id;
    logic       oor;
  } pipe_entry_t;
endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority arbiter, purely combinational.
//   i_req : request vector
//   i_ptr : last winner; the search starts at i_ptr+1 and wraps modulo N
//   o_gnt : one-hot grant, zero when nothing is requesting
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt
);
  logic          w_found;
  logic [PW-1:0] w_idx;

  always_comb begin
    o_gnt   = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int k = 1; k <= N; k++) begin
      w_idx = PW'((int'(i_ptr) + k) % N);
      if (!w_found && i_req[w_idx]) begin
        o_gnt[w_idx] = 1'b1;
        w_found      = 1'b1;
      end
    end
  end
endmodule

// File: rtl/sprite_rom_arbiter.sv
// Shares one synchronous sprite ROM between NUM_REQ requesters.
// One round-robin grant per vga_clk cycle drives the registered ROM address;
// a ROM_LAT-deep pipe carries the requester id so the palette index returns to
// whoever issued the read, as a one-cycle one-hot strobe.
// Ports:
//   vga_clk, reset_n        : clock, async active-low reset
//   req_valid / req_addr    : per-requester request, packed addresses
//   req_ready               : one-hot grant (handshake = valid & ready)
//   rom_address / rom_q     : ROM interface
//   rsp_valid / rsp_data    : one-hot response strobe and palette index
// Optional build macro SPRITE_ROM_ARB_BURST_EN: the winner keeps priority for
// up to BURST_LEN consecutive beats while it keeps requesting.
module sprite_rom_arbiter #(
  parameter int          NUM_REQ   = 4,
  parameter int          ADDR_W    = sprite_rom_arb_pkg::ADDR_W,
  parameter int          DATA_W    = sprite_rom_arb_pkg::DATA_W,
  parameter int unsigned ROM_DEPTH = sprite_rom_arb_pkg::ROM_DEPTH,
  parameter int          ROM_LAT   = 1,
  parameter int          BURST_LEN = 4
) (
  input  logic                      vga_clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [ADDR_W-1:0]         rom_address,
  input  logic [DATA_W-1:0]         rom_q,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data
);
  import sprite_rom_arb_pkg::*;

  localparam int PW = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || ROM_LAT < 1 || ROM_LAT > 3 || BURST_LEN < 1) begin : g_bad_cfg
    $error("sprite_rom_arbiter: parameter out of range");
  end

  logic [PW-1:0]      r_ptr;
  logic [PW-1:0]      w_arb_ptr;
  logic [PW-1:0]      w_gidx;
  logic [NUM_REQ-1:0] w_gnt;
  logic [ADDR_W-1:0]  w_gaddr;
  logic               w_hs;
  logic               w_oor;
  pipe_entry_t        r_pipe [ROM_LAT];
  pipe_entry_t        w_last;
  logic [NUM_REQ-1:0] w_rsp_oh;

  rr_arbiter #(.N(NUM_REQ), .PW(PW)) u_rr (
    .i_req (req_valid),
    .i_ptr (w_arb_ptr),
    .o_gnt (w_gnt)
  );

  // No grants while reset is held, so nothing can handshake into a dead pipe.
  assign req_ready = reset_n ? w_gnt : '0;
  assign w_hs      = |req_ready;

  always_comb begin
    w_gidx  = '0;
    w_gaddr = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_gnt[i]) begin
        w_gidx  = PW'(i);
        w_gaddr = req_addr[i*ADDR_W +: ADDR_W];
      end
    end
  end

  assign w_oor = (32'(w_gaddr) >= ROM_DEPTH);

`ifdef SPRITE_ROM_ARB_BURST_EN
  localparam int CW = $clog2(BURST_LEN + 1);

  logic [CW-1:0] r_beats;
  logic          w_keep;

  // Keeping priority = start the search at the last winner instead of after it.
  assign w_keep    = (r_beats != '0) && (r_beats < CW'(BURST_LEN));
  assign w_arb_ptr = !w_keep          ? r_ptr :
                     (r_ptr == '0)    ? PW'(NUM_REQ - 1) :
                                        r_ptr - PW'(1);

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n)                                      r_beats <= '0;
    else if (!w_hs)                                    r_beats <= '0;
    else if (w_gidx != r_ptr || r_beats == CW'(BURST_LEN)) r_beats <= CW'(1);
    else                                               r_beats <= r_beats + CW'(1);
  end
`else
  assign w_arb_ptr = r_ptr;
`endif

  assign w_last = r_pipe[ROM_LAT-1];

  always_comb begin
    w_rsp_oh = '0;
    for (int i = 0; i < NUM_REQ; i++) w_rsp_oh[i] = (w_last.id == 3'(i));
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      rom_address <= '0;
      rsp_valid   <= '0;
      rsp_data    <= '0;
      r_ptr       <= PW'(NUM_REQ - 1);
      for (int k = 0; k < ROM_LAT; k++) r_pipe[k] <= '0;
    end else begin
      if (w_hs) begin
        rom_address <= w_oor ? '0 : w_gaddr;
        r_ptr       <= w_gidx;
      end
      r_pipe[0] <= '{vld: w_hs, id: 3'(w_gidx), oor: w_hs & w_oor};
      for (int k = 1; k < ROM_LAT; k++) r_pipe[k] <= r_pipe[k-1];
      // Last stage lines up with rom_q for the address registered ROM_LAT edges ago.
      if (w_last.vld) begin
        rsp_valid <= w_rsp_oh;
        rsp_data  <= w_last.oor ? DATA_W'(TRANSPARENT_IDX) : rom_q;
      end else begin
        rsp_valid <= '0;
      end
    end
  end
endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Self-checking bench for sprite_rom_arbiter: directed scenarios followed by a
// randomized phase, all checked against a transaction-level model (last-winner
// index, queue of expected responses keyed by due cycle, ROM contents array).
module tb_sprite_rom_arbiter;
  localparam int N     = 4;
  localparam int AW    = 11;
  localparam int DW    = 3;
  localparam int DEPTH = 1560;
  localparam int LAT   = 1;
  localparam int BL    = 4;

  logic              vga_clk = 1'b0;
  logic              reset_n;
  logic [N-1:0]      req_valid;
  logic [N*AW-1:0]   req_addr;
  logic [N-1:0]      req_ready;
  logic [AW-1:0]     rom_address;
  logic [DW-1:0]     rom_q;
  logic [N-1:0]      rsp_valid;
  logic [DW-1:0]     rsp_data;

  logic [DW-1:0] rom_mem [0:2047];

  always #5 vga_clk = ~vga_clk;

  // Address register inside the DUT is the ROM's input register.
  assign rom_q = rom_mem[rom_address];

  sprite_rom_arbiter #(
    .NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .ROM_DEPTH(DEPTH), .ROM_LAT(LAT), .BURST_LEN(BL)
  ) dut (
    .vga_clk     (vga_clk),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_addr    (req_addr),
    .req_ready   (req_ready),
    .rom_address (rom_address),
    .rom_q       (rom_q),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    int            id;
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  exp_t          q[$];
  int            m_last;
  int            m_beats;
  int            edge_n;
  int            last_g;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic int model_grant();
    int i;
`ifdef SPRITE_ROM_ARB_BURST_EN
    if (m_beats > 0 && m_beats < BL && req_valid[m_last]) return m_last;
`endif
    for (int k = 1; k <= N; k++) begin
      i = (m_last + k) % N;
      if (req_valid[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_last  = N - 1;
    m_beats = 0;
    q.delete();
    m_addr  = '0;
    m_data  = '0;
    last_g  = -1;
  endtask

  task automatic set_addr(input int i, input logic [AW-1:0] a);
    req_addr[i*AW +: AW] = a;
  endtask

  function automatic logic [AW-1:0] rnd_addr();
    if ($urandom_range(0, 9) == 0) return AW'($urandom_range(DEPTH, 2047));
    return AW'($urandom_range(0, DEPTH - 1));
  endfunction

  // One clock: check grant, advance the model at the edge, check outputs after it.
  task automatic tick();
    int            g;
    logic [AW-1:0] a;
    logic [31:0]   ev;
    #1;
    g = model_grant();
    chk("req_ready", 32'(req_ready), (g < 0) ? 32'd0 : (32'd1 << g));
    @(posedge vga_clk);
    edge_n++;
    if (g >= 0) begin
      a = req_addr[g*AW +: AW];
      if (g == m_last && m_beats > 0 && m_beats < BL) m_beats++;
      else                                            m_beats = 1;
      m_last = g;
      m_addr = (a >= AW'(DEPTH)) ? '0 : a;
      q.push_back('{id: g, data: (a >= AW'(DEPTH)) ? DW'(0) : rom_mem[a], due: edge_n + LAT});
    end else begin
      m_beats = 0;
    end
    last_g = g;
    #1;
    ev = 0;
    if (q.size() > 0 && q[0].due == edge_n) begin
      ev     = 32'd1 << q[0].id;
      m_data = q[0].data;
      void'(q.pop_front());
    end
    chk("rsp_valid", 32'(rsp_valid), ev);
    chk("rsp_data", 32'(rsp_data), 32'(m_data));
    chk("rom_address", 32'(rom_address), 32'(m_addr));
    @(negedge vga_clk);
  endtask

  // Granted requester immediately re-requests with a fresh address.
  task automatic refresh_granted();
    if (last_g >= 0) set_addr(last_g, rnd_addr());
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 2048; i++) rom_mem[i] = DW'($urandom_range(0, 7));
    edge_n    = 0;
    reset_n   = 1'b0;
    req_valid = '1;
    req_addr  = '0;
    for (int i = 0; i < N; i++) set_addr(i, rnd_addr());
    model_reset();

    // Reset state: no grants even with every requester asking.
    #3;
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_rom_address", 32'(rom_address), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data), 32'd0);
    repeat (2) @(posedge vga_clk);
    @(negedge vga_clk);
    reset_n = 1'b1;

    // All four continuously valid: 0,1,2,3,0,... one response per cycle.
    for (int n = 0; n < 9; n++) begin
      tick();
      refresh_granted();
    end
    req_valid = '0;
    repeat (2) tick();

    // Single requester 2 at address 61.
    set_addr(2, AW'(61));
    req_valid = 4'b0100;
    tick();
    req_valid = '0;
    repeat (3) tick();

    // Requester 3 withdraws while competing with 0.
    set_addr(3, rnd_addr());
    req_valid = 4'b1000;
    tick();
    req_valid = '0;
    tick();
    set_addr(0, rnd_addr());
    set_addr(3, rnd_addr());
    req_valid = 4'b1001;
    tick();
    refresh_granted();
    req_valid[3] = 1'b0;
    for (int n = 0; n < 3; n++) begin
      tick();
      refresh_granted();
    end
    req_valid = '0;
    repeat (2) tick();

    // Out-of-range address on requester 1, requester 2 right behind it.
    set_addr(1, AW'(1560));
    set_addr(2, AW'(5));
    req_valid = 4'b0110;
    tick();
    req_valid[last_g] = 1'b0;
    tick();
    req_valid = '0;
    repeat (2) tick();

    // Requesters 0 and 1 always valid (burst pattern when enabled).
    set_addr(0, rnd_addr());
    set_addr(1, rnd_addr());
    req_valid = 4'b0011;
    for (int n = 0; n < 12; n++) begin
      tick();
      refresh_granted();
    end
    req_valid = '0;
    repeat (2) tick();

    // Reset with one read in flight: its response must never appear.
    set_addr(0, AW'(100));
    req_valid = 4'b0001;
    tick();
    reset_n = 1'b0;
    model_reset();
    #1;
    chk("midrst_ready", 32'(req_ready), 32'd0);
    chk("midrst_rom_address", 32'(rom_address), 32'd0);
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    for (int n = 0; n < 2; n++) begin
      @(posedge vga_clk);
      #1;
      chk("midrst_no_rsp", 32'(rsp_valid), 32'd0);
    end
    @(negedge vga_clk);
    reset_n   = 1'b1;
    req_valid = '1;
    for (int i = 0; i < N; i++) set_addr(i, rnd_addr());
    for (int n = 0; n < 4; n++) begin
      tick();
      refresh_granted();
    end
    req_valid = '0;
    repeat (2) tick();

    // Randomized traffic with holds, re-requests and withdrawals.
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < N; i++) begin
        if (req_valid[i]) begin
          if (last_g == i) begin
            if ($urandom_range(0, 9) < 6) set_addr(i, rnd_addr());
            else                          req_valid[i] = 1'b0;
          end else if ($urandom_range(0, 31) == 0) begin
            req_valid[i] = 1'b0;
          end
        end else if ($urandom_range(0, 9) < 4) begin
          req_valid[i] = 1'b1;
          set_addr(i, rnd_addr());
        end
      end
      tick();
    end
    req_valid = '0;
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
